peripheral_msi_mux_wb: RTL

PERIPHERAL_MSI_MUX_WB -- requirements
Module: peripheral_msi_mux_wb

---
 rtl/peripheral_msi_wb_pkg.sv | 25 ++
 rtl/peripheral_msi_decoder_wb.sv | 27 ++
 rtl/peripheral_msi_mux_wb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/peripheral_msi_wb_pkg.sv
// Shared types and Wishbone encodings for the MSI Wishbone slave-port multiplexer.
package peripheral_msi_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DECERR = 2'd2,
      ST_ABORT  = 2'd3
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/peripheral_msi_decoder_wb.sv
// Address window match with lowest-index priority; purely combinational.
module peripheral_msi_decoder_wb #(
   parameter int                       AW         = 32,
   parameter int                       NUM_SLAVES = 2,
   parameter int                       IW         = 1,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0
) (
   input  logic [AW-1:0] adr,
   output logic          match_valid,
   output logic [IW-1:0] match_idx
);

   // Scanning from the top down lets the lowest matching index overwrite last.
   always_comb begin
      match_valid = 1'b0;
      match_idx   = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((adr & MATCH_MASK[i*AW +: AW]) ==
             (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
            match_valid = 1'b1;
            match_idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/peripheral_msi_mux_wb.sv
// Wishbone 1:N slave-port multiplexer with decode error and response timeout.
// state  | meaning
// IDLE   | no cycle owned; decode master cyc&stb
// ACTIVE | slave_sel owns the cycle; responses routed back
// DECERR | address hit no window; one-cycle err to master
// ABORT  | timed out; slaves released until master drops cyc
module peripheral_msi_mux_wb
   import peripheral_msi_wb_pkg::*;
#(
   parameter int                       DW         = 32,
   parameter int                       AW         = 32,
   parameter int                       NUM_SLAVES = 2,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
   parameter int                       TIMEOUT    = 255
) (
   input  logic                                wb_clk_i,
   input  logic                                wb_rst_i,
   input  logic [AW-1:0]                       wbm_adr_i,
   input  logic [DW-1:0]                       wbm_dat_i,
   input  logic [3:0]                          wbm_sel_i,
   input  logic                                wbm_we_i,
   input  logic                                wbm_cyc_i,
   input  logic                                wbm_stb_i,
   input  logic [2:0]                          wbm_cti_i,
   input  logic [1:0]                          wbm_bte_i,
   output logic [DW-1:0]                       wbm_dat_o,
   output logic                                wbm_ack_o,
   output logic                                wbm_err_o,
   output logic                                wbm_rty_o,
   output logic [NUM_SLAVES-1:0][AW-1:0]       wbs_adr_o,
   output logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_o,
   output logic [NUM_SLAVES-1:0][3:0]          wbs_sel_o,
   output logic [NUM_SLAVES-1:0]               wbs_we_o,
   output logic [NUM_SLAVES-1:0]               wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]               wbs_stb_o,
   output logic [NUM_SLAVES-1:0][2:0]          wbs_cti_o,
   output logic [NUM_SLAVES-1:0][1:0]          wbs_bte_o,
   input  logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]               wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]               wbs_err_i,
   input  logic [NUM_SLAVES-1:0]               wbs_rty_i
);

   localparam int IW = idx_width(NUM_SLAVES);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t          state, state_nxt;
   logic [IW-1:0]   slave_sel;
   logic [CW-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic            dec_valid;
   logic [IW-1:0]   dec_idx;
   logic            sel_ack, sel_err, sel_rty, slave_resp, tmo_hit;

   peripheral_msi_decoder_wb #(
      .AW         (AW),
      .NUM_SLAVES (NUM_SLAVES),
      .IW         (IW),
      .MATCH_ADDR (MATCH_ADDR),
      .MATCH_MASK (MATCH_MASK)
   ) u_decoder (
      .adr         (wbm_adr_i),
      .match_valid (dec_valid),
      .match_idx   (dec_idx)
   );

   assign sel_ack    = wbs_ack_i[slave_sel];
   assign sel_err    = wbs_err_i[slave_sel];
   assign sel_rty    = wbs_rty_i[slave_sel];
   assign slave_resp = sel_ack | sel_err | sel_rty;
   // A slave answer in the terminal-count cycle wins over the timeout.
   assign tmo_hit    = (TIMEOUT > 0) && (state == ST_ACTIVE) && wbm_stb_i &&
                       !slave_resp && (tmo_cnt == CW'(TIMEOUT));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         slave_sel <= '0;
         tmo_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_cnt_nxt;
         if (state == ST_IDLE && wbm_cyc_i && wbm_stb_i && dec_valid)
            slave_sel <= dec_idx;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = '0;
      wbs_cyc_o   = '0;
      wbs_stb_o   = '0;
      wbm_ack_o   = 1'b0;
      wbm_err_o   = 1'b0;
      wbm_rty_o   = 1'b0;
      wbm_dat_o   = '0;
      case (state)
         ST_IDLE: begin
            if (wbm_cyc_i && wbm_stb_i)
               state_nxt = dec_valid ? ST_ACTIVE : ST_DECERR;
         end
         ST_ACTIVE: begin
            wbs_cyc_o[slave_sel] = wbm_cyc_i;
            wbs_stb_o[slave_sel] = wbm_stb_i;
            wbm_dat_o            = wbs_dat_i[slave_sel];
            if (tmo_hit) begin
               wbm_err_o = 1'b1;
            end else begin
               wbm_ack_o = sel_ack;
               wbm_err_o = !sel_ack && sel_err;
               wbm_rty_o = !sel_ack && !sel_err && sel_rty;
               if (TIMEOUT > 0 && wbm_stb_i && !slave_resp)
                  tmo_cnt_nxt = tmo_cnt + CW'(1);
            end
            if (!wbm_cyc_i)
               state_nxt = ST_IDLE;
            else if (tmo_hit)
               state_nxt = ST_ABORT;
         end
         ST_DECERR: begin
            wbm_err_o = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ABORT: begin
            if (!wbm_cyc_i)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Reset cuts the transfer off immediately so no stray response leaks out.
      if (wb_rst_i) begin
         wbs_cyc_o = '0;
         wbs_stb_o = '0;
         wbm_ack_o = 1'b0;
         wbm_err_o = 1'b0;
         wbm_rty_o = 1'b0;
         wbm_dat_o = '0;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
         wbs_adr_o[i] = wbm_adr_i;
         wbs_dat_o[i] = wbm_dat_i;
         wbs_sel_o[i] = wbm_sel_i;
         wbs_we_o[i]  = wbm_we_i;
         wbs_cti_o[i] = wbm_cti_i;
         wbs_bte_o[i] = wbm_bte_i;
      end
   end

endmodule
